brick_scene_renderer: RTL and testbench

- Pixel-colour source feeding the VGA driver's 8-bit RRRGGGBB colour input.
- Holds the live brick map, bricks-remaining count, and frame-latched paddle/ball positions.
- Returns the colour for the driver's next-pixel coordinates in the same cycle.
- Gives game logic a brick-clear handshake, a brick query port, and a once-per-frame tick.

---
 rtl/brick_pkg.sv | 34 +++
 rtl/brick_map.sv | 71 +++++++
 rtl/brick_scene_renderer.sv | 143 ++++++++++++++
 tb/tb_brick_scene_renderer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared geometry defaults and colour table for the brick scene renderer.
// Colours are 8-bit RRRGGGBB as expected by the VGA driver.
package brick_pkg;

    localparam int DEF_ROWS      = 6;
    localparam int DEF_COLS      = 10;
    localparam int DEF_BRICK_W   = 64;
    localparam int DEF_BRICK_H   = 16;
    localparam int DEF_BRICK_TOP = 32;
    localparam int DEF_GAP       = 2;
    localparam int DEF_PADDLE_Y  = 448;
    localparam int DEF_PADDLE_W  = 64;
    localparam int DEF_PADDLE_H  = 8;
    localparam int DEF_BALL_SIZE = 8;

    localparam logic [7:0] COLOR_BG     = 8'h00;
    localparam logic [7:0] COLOR_PADDLE = 8'hFF;
    localparam logic [7:0] COLOR_BALL   = 8'hFC;

    // Six-entry palette; rows 6 and 7 reuse the colours of rows 0 and 1.
    function automatic logic [7:0] row_color(input logic [2:0] row);
        logic [7:0] color;
        case (row)
            3'd0, 3'd6: color = 8'hE0;
            3'd1, 3'd7: color = 8'hEC;
            3'd2:       color = 8'hFC;
            3'd3:       color = 8'h1C;
            3'd4:       color = 8'h1F;
            default:    color = 8'hE3;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/brick_map.sv
// Live brick bitmap with remaining-brick count, clear handshake, level reload
// and two combinational lookup ports (game-logic query and renderer).
module brick_map
    import brick_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_level,
    input  logic       brick_clr_valid,
    output logic       brick_clr_ready,
    input  logic [2:0] brick_clr_row,
    input  logic [3:0] brick_clr_col,
    input  logic [2:0] query_row,
    input  logic [3:0] query_col,
    output logic       query_alive,
    input  logic [2:0] render_row,
    input  logic [3:0] render_col,
    output logic       render_alive,
    output logic [6:0] bricks_remaining,
    output logic       all_cleared
);

    localparam int NUM_BRICKS = ROWS * COLS;

    logic [NUM_BRICKS-1:0] alive_reg;
    logic [NUM_BRICKS-1:0] clear_mask;
    logic [7:0][15:0]      full_map;
    logic [6:0]            remaining_reg;
    logic                  all_cleared_reg;
    logic                  clr_hit;

    // Pad the map to the full 8x16 index space so out-of-range lookups read 0.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row
            for (genvar gj = 0; gj < 16; gj++) begin : g_col
                if (gi < ROWS && gj < COLS) begin : g_cell
                    assign full_map[gi][gj] = alive_reg[gi*COLS + gj];
                    assign clear_mask[gi*COLS + gj] = clr_hit
                        && (brick_clr_row == 3'(gi)) && (brick_clr_col == 4'(gj));
                end else begin : g_pad
                    assign full_map[gi][gj] = 1'b0;
                end
            end
        end
    endgenerate

    assign brick_clr_ready = ~reset & ~load_level;
    // Dead or out-of-range targets are accepted but change nothing.
    assign clr_hit      = brick_clr_valid & brick_clr_ready & full_map[brick_clr_row][brick_clr_col];
    assign query_alive  = full_map[query_row][query_col];
    assign render_alive = full_map[render_row][render_col];

    always_ff @(posedge clock) begin
        if (reset || load_level) begin
            alive_reg       <= '1;
            remaining_reg   <= 7'(NUM_BRICKS);
            all_cleared_reg <= 1'b0;
        end else if (clr_hit) begin
            alive_reg       <= alive_reg & ~clear_mask;
            remaining_reg   <= remaining_reg - 7'd1;
            all_cleared_reg <= (remaining_reg == 7'd1);
        end
    end

    assign bricks_remaining = remaining_reg;
    assign all_cleared      = all_cleared_reg;

endmodule

// File: rtl/brick_scene_renderer.sv
// Per-pixel colour source for the VGA driver: frame-latched paddle/ball
// shadows, brick/paddle/ball hit tests and a fixed-priority colour mux.
module brick_scene_renderer
    import brick_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int BRICK_W   = DEF_BRICK_W,
    parameter int BRICK_H   = DEF_BRICK_H,
    parameter int BRICK_TOP = DEF_BRICK_TOP,
    parameter int GAP       = DEF_GAP,
    parameter int PADDLE_Y  = DEF_PADDLE_Y,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       vsync,
    input  logic [9:0] paddle_x,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       ball_visible,
    input  logic       load_level,
    input  logic       brick_clr_valid,
    output logic       brick_clr_ready,
    input  logic [2:0] brick_clr_row,
    input  logic [3:0] brick_clr_col,
    input  logic [2:0] query_row,
    input  logic [3:0] query_col,
    output logic       query_alive,
    output logic [7:0] color_out,
    output logic       frame_tick,
    output logic [6:0] bricks_remaining,
    output logic       all_cleared
);

    localparam int LOG_W = $clog2(BRICK_W);
    localparam int LOG_H = $clog2(BRICK_H);

    logic       vsync_d_reg;
    logic       frame_tick_reg;
    logic [9:0] paddle_x_s_reg;
    logic [9:0] ball_x_s_reg;
    logic [9:0] ball_y_s_reg;
    logic       ball_visible_s_reg;
    logic       vsync_fall;

    assign vsync_fall = vsync_d_reg & ~vsync;

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_d_reg        <= 1'b1;
            frame_tick_reg     <= 1'b0;
            paddle_x_s_reg     <= '0;
            ball_x_s_reg       <= '0;
            ball_y_s_reg       <= '0;
            ball_visible_s_reg <= 1'b0;
        end else begin
            vsync_d_reg    <= vsync;
            frame_tick_reg <= vsync_fall;
            if (vsync_fall) begin
                paddle_x_s_reg     <= paddle_x;
                ball_x_s_reg       <= ball_x;
                ball_y_s_reg       <= ball_y;
                ball_visible_s_reg <= ball_visible;
            end
        end
    end

    assign frame_tick = frame_tick_reg;

    logic [9:0]  y_off;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [2:0]  render_row;
    logic [3:0]  render_col;
    logic        render_alive;
    logic        in_field;
    logic        gap_ok;
    logic        brick_hit;
    logic        paddle_hit;
    logic        ball_hit;

    assign x_ext      = {1'b0, pixel_x};
    assign y_ext      = {1'b0, pixel_y};
    assign y_off      = pixel_y - 10'(BRICK_TOP);
    assign render_row = 3'(y_off >> LOG_H);
    assign render_col = 4'(pixel_x >> LOG_W);

    assign in_field = (y_ext >= 11'(BRICK_TOP))
                   && (y_ext < 11'(BRICK_TOP + ROWS*BRICK_H))
                   && (x_ext < 11'(COLS*BRICK_W));
    assign gap_ok   = ((pixel_x & 10'(BRICK_W-1)) < 10'(BRICK_W-GAP))
                   && ((y_off & 10'(BRICK_H-1)) < 10'(BRICK_H-GAP));
    assign brick_hit = in_field & gap_ok & render_alive;

    // 11-bit sums keep objects near the right/bottom edge from wrapping to 0.
    assign paddle_hit = (x_ext >= {1'b0, paddle_x_s_reg})
                     && (x_ext < {1'b0, paddle_x_s_reg} + 11'(PADDLE_W))
                     && (y_ext >= 11'(PADDLE_Y))
                     && (y_ext < 11'(PADDLE_Y + PADDLE_H));
    assign ball_hit = ball_visible_s_reg
                   && (x_ext >= {1'b0, ball_x_s_reg})
                   && (x_ext < {1'b0, ball_x_s_reg} + 11'(BALL_SIZE))
                   && (y_ext >= {1'b0, ball_y_s_reg})
                   && (y_ext < {1'b0, ball_y_s_reg} + 11'(BALL_SIZE));

    always_comb begin
        color_out = COLOR_BG;
        if (ball_hit) begin
            color_out = COLOR_BALL;
        end else if (paddle_hit) begin
            color_out = COLOR_PADDLE;
        end else if (brick_hit) begin
            color_out = row_color(render_row);
        end
    end

    brick_map #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_brick_map (
        .clock            (clock),
        .reset            (reset),
        .load_level       (load_level),
        .brick_clr_valid  (brick_clr_valid),
        .brick_clr_ready  (brick_clr_ready),
        .brick_clr_row    (brick_clr_row),
        .brick_clr_col    (brick_clr_col),
        .query_row        (query_row),
        .query_col        (query_col),
        .query_alive      (query_alive),
        .render_row       (render_row),
        .render_col       (render_col),
        .render_alive     (render_alive),
        .bricks_remaining (bricks_remaining),
        .all_cleared      (all_cleared)
    );

endmodule

// File: tb/tb_brick_scene_renderer.sv
// Directed scenarios plus randomized traffic checked against a pixel-level
// model of the playfield (brick grid, paddle, ball, frame latch).
module tb_brick_scene_renderer;

    localparam int ROWS = 6;
    localparam int COLS = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       vsync;
    logic [9:0] paddle_x, ball_x, ball_y;
    logic       ball_visible;
    logic       load_level;
    logic       brick_clr_valid;
    logic       brick_clr_ready;
    logic [2:0] brick_clr_row;
    logic [3:0] brick_clr_col;
    logic [2:0] query_row;
    logic [3:0] query_col;
    logic       query_alive;
    logic [7:0] color_out;
    logic       frame_tick;
    logic [6:0] bricks_remaining;
    logic       all_cleared;

    always #5 clock = ~clock;

    brick_scene_renderer dut (
        .clock            (clock),
        .reset            (reset),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .vsync            (vsync),
        .paddle_x         (paddle_x),
        .ball_x           (ball_x),
        .ball_y           (ball_y),
        .ball_visible     (ball_visible),
        .load_level       (load_level),
        .brick_clr_valid  (brick_clr_valid),
        .brick_clr_ready  (brick_clr_ready),
        .brick_clr_row    (brick_clr_row),
        .brick_clr_col    (brick_clr_col),
        .query_row        (query_row),
        .query_col        (query_col),
        .query_alive      (query_alive),
        .color_out        (color_out),
        .frame_tick       (frame_tick),
        .bricks_remaining (bricks_remaining),
        .all_cleared      (all_cleared)
    );

    int checks = 0;
    int errors = 0;

    // Reference state of the playfield
    bit m_alive [8][16];
    int m_count;
    bit m_cleared, m_vd, m_tick;
    int s_px, s_bx, s_by;
    bit s_bv;
    int palette [6] = '{'hE0, 'hEC, 'hFC, 'h1C, 'h1F, 'hE3};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_color(input int x, input int y);
        int r, c;
        if (s_bv && x >= s_bx && x < s_bx + 8 && y >= s_by && y < s_by + 8) return 'hFC;
        if (x >= s_px && x < s_px + 64 && y >= 448 && y < 456) return 'hFF;
        if (y >= 32 && y < 32 + ROWS*16 && x < COLS*64) begin
            r = (y - 32) / 16;
            c = x / 64;
            if (m_alive[r][c] && (x % 64) < 62 && ((y - 32) % 16) < 14) return palette[r % 6];
        end
        return 0;
    endfunction

    task automatic refill();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                m_alive[r][c] = (r < ROWS && c < COLS);
        m_count = ROWS * COLS;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_cycle();
        int r, c;
        if (reset) begin
            refill();
            m_cleared = 0; m_tick = 0; m_vd = 1;
            s_px = 0; s_bx = 0; s_by = 0; s_bv = 0;
        end else begin
            m_tick = m_vd && !vsync;
            if (m_tick) begin
                s_px = paddle_x; s_bx = ball_x; s_by = ball_y; s_bv = ball_visible;
            end
            m_vd = vsync;
            r = brick_clr_row;
            c = brick_clr_col;
            if (load_level) begin
                refill();
            end else if (brick_clr_valid && r < ROWS && c < COLS && m_alive[r][c]) begin
                m_alive[r][c] = 0;
                m_count--;
            end
            m_cleared = (m_count == 0);
        end
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        int qa;
        #1;
        qa = (query_row < ROWS && query_col < COLS) ? m_alive[query_row][query_col] : 0;
        check_eq({tag, "_remaining"}, 32'(bricks_remaining), 32'(m_count));
        check_eq({tag, "_all_cleared"}, 32'(all_cleared), 32'(m_cleared));
        check_eq({tag, "_frame_tick"}, 32'(frame_tick), 32'(m_tick));
        check_eq({tag, "_ready"}, 32'(brick_clr_ready), 32'(!reset && !load_level));
        check_eq({tag, "_query"}, 32'(query_alive), 32'(qa));
        check_eq({tag, "_color"}, 32'(color_out), 32'(ref_color(pixel_x, pixel_y)));
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input int exp);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        #1;
        check_eq(tag, 32'(color_out), 32'(exp));
    endtask

    task automatic frame_edge();
        vsync = 1'b0;
        cyc();
        vsync = 1'b1;
    endtask

    initial begin
        reset = 1; pixel_x = 0; pixel_y = 0; vsync = 1;
        paddle_x = 0; ball_x = 0; ball_y = 0; ball_visible = 0;
        load_level = 0; brick_clr_valid = 0; brick_clr_row = 0; brick_clr_col = 0;
        query_row = 0; query_col = 0;
        cyc(); cyc();
        reset = 0;
        check_all("reset");
        check_eq("reset_count", 32'(bricks_remaining), 32'd60);
        pix_check("pix_0_32", 0, 32, 'hE0);
        pix_check("pix_gap_62_32", 62, 32, 'h00);
        pix_check("pix_0_31", 0, 31, 'h00);

        // Single clear, then repeat of the same brick
        brick_clr_valid = 1; brick_clr_row = 2; brick_clr_col = 3;
        #1 check_eq("clr_ready", 32'(brick_clr_ready), 32'd1);
        cyc();
        brick_clr_valid = 0; query_row = 2; query_col = 3;
        #1 check_eq("clr_count", 32'(bricks_remaining), 32'd59);
        check_eq("clr_query", 32'(query_alive), 32'd0);
        pix_check("clr_pix", 192, 64, 'h00);
        brick_clr_valid = 1;
        cyc();
        brick_clr_valid = 0;
        #1 check_eq("clr_repeat", 32'(bricks_remaining), 32'd59);

        // Paddle only appears after the frame latch
        paddle_x = 100;
        cyc(); cyc();
        pix_check("paddle_pre", 100, 448, 'h00);
        frame_edge();
        #1 check_eq("paddle_tick", 32'(frame_tick), 32'd1);
        pix_check("paddle_post", 100, 448, 'hFF);
        pix_check("paddle_left", 99, 448, 'h00);
        cyc();
        #1 check_eq("tick_once", 32'(frame_tick), 32'd0);

        ball_x = 100; ball_y = 444; ball_visible = 1;
        frame_edge();
        pix_check("ball_over_paddle", 100, 448, 'hFC);
        ball_visible = 0;
        cyc();
        frame_edge();
        pix_check("ball_hidden", 100, 448, 'hFF);

        // Clear everything back-to-back
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                brick_clr_valid = 1; brick_clr_row = 3'(r); brick_clr_col = 4'(c);
                cyc();
            end
        end
        brick_clr_valid = 0;
        check_all("drained");
        check_eq("drained_flag", 32'(all_cleared), 32'd1);

        load_level = 1; brick_clr_valid = 1; brick_clr_row = 0; brick_clr_col = 0;
        #1 check_eq("load_ready", 32'(brick_clr_ready), 32'd0);
        cyc();
        load_level = 0; brick_clr_valid = 0; query_row = 0; query_col = 0;
        #1 check_eq("load_count", 32'(bricks_remaining), 32'd60);
        check_eq("load_flag", 32'(all_cleared), 32'd0);
        check_eq("load_query", 32'(query_alive), 32'd1);

        // Out-of-range clears are accepted and ignored
        brick_clr_valid = 1; brick_clr_row = 6; brick_clr_col = 0;
        cyc();
        brick_clr_row = 0; brick_clr_col = 10;
        cyc();
        brick_clr_valid = 0; query_row = 6; query_col = 0;
        check_all("oor");
        check_eq("oor_count", 32'(bricks_remaining), 32'd60);

        paddle_x = 600;
        frame_edge();
        pix_check("paddle_edge", 639, 452, 'hFF);
        pix_check("paddle_nowrap", 20, 452, 'h00);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            vsync = !((i % 113) < 2 || $urandom_range(0, 49) == 0);
            load_level = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) begin
                paddle_x = 10'($urandom_range(0, 1023));
                ball_x = 10'($urandom_range(0, 1023));
                ball_y = 10'($urandom_range(0, 1023));
                ball_visible = 1'($urandom_range(0, 1));
            end
            brick_clr_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                brick_clr_row = 3'($urandom_range(0, 7));
                brick_clr_col = 4'($urandom_range(0, 15));
            end else begin
                brick_clr_row = 3'($urandom_range(0, ROWS - 1));
                brick_clr_col = 4'($urandom_range(0, COLS - 1));
            end
            query_row = 3'($urandom_range(0, 7));
            query_col = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin pixel_x = 10'($urandom_range(0, 1023)); pixel_y = 10'($urandom_range(0, 1023)); end
                1: begin pixel_x = 10'($urandom_range(0, 660)); pixel_y = 10'($urandom_range(24, 136)); end
                2: begin pixel_x = 10'(s_px + $urandom_range(0, 70) - 3); pixel_y = 10'($urandom_range(444, 460)); end
                default: begin pixel_x = 10'(s_bx + $urandom_range(0, 10) - 1); pixel_y = 10'(s_by + $urandom_range(0, 10) - 1); end
            endcase
            check_all("rand");
            cyc();
        end
        reset = 0; load_level = 0; brick_clr_valid = 0;
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
